mcse_ahb_responder: RTL

//  AHB-Lite subordinate: the far end of the MCSE system-side AHB requester port.

---
 rtl/mcse_ahb_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mcse_ahb_responder.sv
// AHB-Lite subordinate with a word-addressed register memory, programmable wait states and ERROR responses.
// Optional feature macro: AHB_RESP_WRPROT_EN (write-protects the low pPROT_WORDS words while wr_lock=1).
module mcse_ahb_responder #(
  parameter int                          pAHB_DATA_WIDTH  = 32,
  parameter int                          pAHB_ADDR_WIDTH  = 32,
  parameter int                          pAHB_HRESP_WIDTH = 2,
  parameter logic [pAHB_ADDR_WIDTH-1:0]  pBASE_ADDR       = 32'h4000_0000,
  parameter int                          pDEPTH           = 16,
  parameter int                          pWAIT_STATES     = 0,
  parameter int                          pPROT_WORDS      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hsel,
  input  logic [pAHB_ADDR_WIDTH-1:0]    haddr,
  input  logic [1:0]                    htrans,
  input  logic                          hwrite,
  input  logic [2:0]                    hsize,
  input  logic [2:0]                    hburst,
  input  logic [3:0]                    hprot,
  input  logic                          hmastlock,
  input  logic                          hnonsec,
  input  logic [pAHB_DATA_WIDTH-1:0]    hwdata,
  input  logic                          hready,
  input  logic                          wr_lock,
  output logic [pAHB_DATA_WIDTH-1:0]    hrdata,
  output logic                          hreadyout,
  output logic [pAHB_HRESP_WIDTH-1:0]   hresp
);

  localparam int AW = pAHB_ADDR_WIDTH;
  localparam int DW = pAHB_DATA_WIDTH;
  localparam int IW = $clog2(pDEPTH);
  localparam logic [pAHB_HRESP_WIDTH-1:0] RESP_OKAY  = '0;
  localparam logic [pAHB_HRESP_WIDTH-1:0] RESP_ERROR = pAHB_HRESP_WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [IW-1:0]   idx_reg;
  logic            write_reg;
  logic [DW-1:0]   mem_reg [pDEPTH];

  logic [AW-1:0]   offset;
  logic [IW-1:0]   addr_idx;
  logic            illegal;
  logic            can_accept;
  logic            accept;
  logic            wr_en;
  state_t          accept_state;

  assign offset   = haddr - pBASE_ADDR;
  assign addr_idx = offset[IW+1:2];

`ifdef AHB_RESP_WRPROT_EN
  logic prot_hit;
  assign prot_hit = hwrite && wr_lock && (int'(addr_idx) < pPROT_WORDS);
`else
  logic prot_hit;
  assign prot_hit = 1'b0;
`endif

  assign illegal = (offset >= AW'(pDEPTH * 4)) || (haddr[1:0] != 2'b00) ||
                   (hsize != 3'b010) || prot_hit;

  // A new address phase can only be taken while the bus sees us ready.
  assign can_accept = (state_reg == S_IDLE) || (state_reg == S_DATA) || (state_reg == S_ERR2);
  assign accept     = can_accept && hsel && hready && htrans[1];
  assign wr_en      = (state_reg == S_DATA) && write_reg;

  always_comb begin
    accept_state = S_DATA;
    if (illegal)
      accept_state = S_ERR1;
    else if (pWAIT_STATES > 0)
      accept_state = S_WAIT;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hreadyout  = 1'b1;
    hresp      = RESP_OKAY;
    hrdata     = '0;
    case (state_reg)
      S_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_reg == 4'(pWAIT_STATES - 1)) begin
          state_next = S_DATA;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      S_ERR1: begin
        hreadyout  = 1'b0;
        hresp      = RESP_ERROR;
        state_next = S_ERR2;
      end
      S_ERR2: begin
        hresp      = RESP_ERROR;
        state_next = accept ? accept_state : S_IDLE;
        cnt_next   = 4'd0;
      end
      S_DATA: begin
        if (!write_reg)
          hrdata = mem_reg[idx_reg];
        state_next = accept ? accept_state : S_IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = accept ? accept_state : S_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        idx_reg   <= addr_idx;
        write_reg <= hwrite;
      end
    end
  end

  // Write data arrives in the data phase, so commit happens on the S_DATA edge.
  for (genvar gi = 0; gi < pDEPTH; gi++) begin : g_mem
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        mem_reg[gi] <= '0;
      else if (wr_en && (idx_reg == IW'(gi)))
        mem_reg[gi] <= hwdata;
    end
  end

  logic unused_sig;
  assign unused_sig = ^{hburst, hprot, hmastlock, hnonsec, offset[1:0], wr_lock};

endmodule
